bus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one slave port between NrHosts bus hosts. Typical uses: the RAM data port, or the bus's device side once a second host (e.g. a DMA engine) sits next to the core data port.
- Speaks the core's req/gnt/rvalid protocol on both sides.
- Tracks the host ID of every outstanding transaction, so each response returns to the host that issued it.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_arb_id_fifo.sv | 70 +++++++
 rtl/bus_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared defaults, ID-width helper and host ID type
// for the round-robin bus arbiter.
package bus_arb_pkg;

   localparam int unsigned NrHostsDflt        = 2;
   localparam int unsigned DataWidthDflt      = 32;
   localparam int unsigned AddressWidthDflt   = 32;
   localparam int unsigned MaxOutstandingDflt = 2;

   // A single host still needs a 1-bit ID so the FIFO has a payload.
   function automatic int unsigned id_width(input int unsigned nr);
      return (nr > 2) ? $clog2(nr) : 1;
   endfunction

   typedef logic [id_width(NrHostsDflt)-1:0] host_id_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Synchronous FIFO holding the host ID of every granted,
// not yet answered transaction.
module bus_arb_id_fifo
   import bus_arb_pkg::*;
#(
   parameter int unsigned Depth = MaxOutstandingDflt,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointers wrap explicitly so any depth works, not only powers of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid slave among NrHosts hosts.
// Optional per-host grant counters: define BUS_RR_ARBITER_STATS_EN.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NrHosts        = NrHostsDflt,
   parameter int unsigned DataWidth      = DataWidthDflt,
   parameter int unsigned AddressWidth   = AddressWidthDflt,
   parameter int unsigned MaxOutstanding = MaxOutstandingDflt
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*(DataWidth/8)-1:0]  host_be_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   output logic                              dev_req_o,
   input  logic                              dev_gnt_i,
   output logic [AddressWidth-1:0]           dev_addr_o,
   output logic                              dev_we_o,
   output logic [DataWidth/8-1:0]            dev_be_o,
   output logic [DataWidth-1:0]              dev_wdata_o,
   input  logic                              dev_rvalid_i,
   input  logic [DataWidth-1:0]              dev_rdata_i,
   input  logic                              dev_err_i,
`ifdef BUS_RR_ARBITER_STATS_EN
   output logic [NrHosts*32-1:0]             grant_cnt_o,
`endif
   output logic                              protocol_err_o
);

   localparam int unsigned IdW = id_width(NrHosts);
   localparam int unsigned BeW = DataWidth / 8;

   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0] sel;
   logic [IdW-1:0] head_id;
   logic           found;
   int unsigned    idx;
   logic           req_any;
   logic           accept;
   logic           resp_ok;
   logic           fifo_full, fifo_empty;
   logic           protocol_err_q, protocol_err_d;

   assign req_any = |host_req_i;

   // Scan from the pointer upward, wrapping modulo NrHosts.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < NrHosts; k++) begin
         idx = (int'(rr_ptr_q) + k) % NrHosts;
         if (!found && host_req_i[IdW'(idx)]) begin
            sel   = IdW'(idx);
            found = 1'b1;
         end
      end
   end

   // Full is taken from the registered count only; a same-cycle pop
   // does not free a slot until the next cycle.
   assign dev_req_o = req_any & ~fifo_full & ~rst_i;
   assign accept    = dev_req_o & dev_gnt_i;
   assign resp_ok   = dev_rvalid_i & ~fifo_empty & ~rst_i;

   always_comb begin
      dev_addr_o  = '0;
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      host_gnt_o  = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         if (req_any && sel == IdW'(i)) begin
            dev_addr_o  = host_addr_i[i*AddressWidth +: AddressWidth];
            dev_we_o    = host_we_i[i];
            dev_be_o    = host_be_i[i*BeW +: BeW];
            dev_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
            host_gnt_o[i] = accept;
         end
      end
   end

   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         if (resp_ok && head_id == IdW'(i)) begin
            host_rvalid_o[i] = 1'b1;
            host_err_o[i]    = dev_err_i;
         end
      end
   end

   assign host_rdata_o = {NrHosts{dev_rdata_i}};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (sel == IdW'(NrHosts - 1)) ? '0 : sel + 1'b1;
      end
   end

   assign protocol_err_d = protocol_err_q | (dev_rvalid_i & fifo_empty);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q       <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign protocol_err_o = protocol_err_q;

   bus_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .data_i  (sel),
      .pop_i   (resp_ok),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef BUS_RR_ARBITER_STATS_EN
   logic [31:0] grant_cnt_q [NrHosts];
   logic [31:0] grant_cnt_d [NrHosts];

   always_comb begin
      for (int unsigned i = 0; i < NrHosts; i++) begin
         grant_cnt_d[i] = grant_cnt_q[i];
         if (host_gnt_o[i] && grant_cnt_q[i] != 32'hFFFF_FFFF) begin
            grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < NrHosts; i++) begin
         if (rst_i) begin
            grant_cnt_q[i] <= '0;
         end else begin
            grant_cnt_q[i] <= grant_cnt_d[i];
         end
      end
   end

   always_comb begin
      grant_cnt_o = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (2 hosts, 2 outstanding).
// Also checks grant counters when BUS_RR_ARBITER_STATS_EN is defined.
module tb_bus_rr_arbiter;

   localparam logic [31:0] A0 = 32'h0020_0010;
   localparam logic [31:0] A1 = 32'h0030_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [63:0] addr;
   logic [1:0]  we;
   logic [7:0]  be;
   logic [63:0] wdata;
   logic [1:0]  rvalid;
   logic [63:0] rdata;
   logic [1:0]  err;
   logic        dev_req;
   logic        dev_gnt;
   logic [31:0] dev_addr;
   logic        dev_we;
   logic [3:0]  dev_be;
   logic [31:0] dev_wdata;
   logic        dev_rvalid;
   logic [31:0] dev_rdata;
   logic        dev_err;
   logic        perr;
`ifdef BUS_RR_ARBITER_STATS_EN
   logic [63:0] gcnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [1:0] prev;

   always #5 clk = ~clk;

   bus_rr_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .host_req_i     (req),
      .host_gnt_o     (gnt),
      .host_addr_i    (addr),
      .host_we_i      (we),
      .host_be_i      (be),
      .host_wdata_i   (wdata),
      .host_rvalid_o  (rvalid),
      .host_rdata_o   (rdata),
      .host_err_o     (err),
      .dev_req_o      (dev_req),
      .dev_gnt_i      (dev_gnt),
      .dev_addr_o     (dev_addr),
      .dev_we_o       (dev_we),
      .dev_be_o       (dev_be),
      .dev_wdata_o    (dev_wdata),
      .dev_rvalid_i   (dev_rvalid),
      .dev_rdata_i    (dev_rdata),
      .dev_err_i      (dev_err),
`ifdef BUS_RR_ARBITER_STATS_EN
      .grant_cnt_o    (gcnt),
`endif
      .protocol_err_o (perr)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      req        = 2'b11;
      addr       = {A1, A0};
      we         = 2'b10;
      be         = 8'hF3;
      wdata      = {32'h1111_2222, 32'h3333_4444};
      dev_gnt    = 1'b1;
      dev_rvalid = 1'b1;
      dev_rdata  = '0;
      dev_err    = 1'b0;
      #2;
      chk("rst_dev_req", 64'(dev_req), 64'd0);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      tick;
      chk("rst_perr", 64'(perr), 64'd0);
`ifdef BUS_RR_ARBITER_STATS_EN
      chk("rst_gcnt", gcnt, 64'd0);
`endif

      // Single host, 1-cycle RAM.
      rst = 1'b0; req = 2'b01; dev_rvalid = 1'b0;
      #1;
      chk("single_gnt", 64'(gnt), 64'b01);
      chk("single_addr", 64'(dev_addr), 64'(A0));
      chk("single_we", 64'(dev_we), 64'd0);
      chk("single_be", 64'(dev_be), 64'h3);
      tick;
      req = 2'b00; dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_BEEF;
      #1;
      chk("single_rvalid", 64'(rvalid), 64'b01);
      chk("single_rdata", 64'(rdata[31:0]), 64'hDEAD_BEEF);
      chk("single_err", 64'(err), 64'd0);
      chk("idle_addr", 64'(dev_addr), 64'd0);
      tick;
      dev_rvalid = 1'b0;

      // Contention from reset: alternate grants, responses follow.
      rst = 1'b1;
      tick;
      rst = 1'b0; req = 2'b11; dev_gnt = 1'b1;
      prev = 2'b00;
      for (int k = 0; k < 6; k++) begin
         dev_rvalid = (k > 0);
         dev_rdata  = 32'hA000_0000 + 32'(k);
         #1;
         chk("cont_gnt", 64'(gnt), (k % 2 == 1) ? 64'b10 : 64'b01);
         if (k > 0) begin
            chk("cont_rvalid", 64'(rvalid), 64'(prev));
            chk("cont_rdata", 64'(rdata), {2{32'hA000_0000 + 32'(k)}});
         end
         prev = (k % 2 == 1) ? 2'b10 : 2'b01;
         tick;
      end
      req = 2'b00; dev_rvalid = 1'b1;
      #1;
      chk("cont_last_rvalid", 64'(rvalid), 64'b10);
`ifdef BUS_RR_ARBITER_STATS_EN
      chk("cont_gcnt", gcnt, {32'd3, 32'd3});
`endif
      tick;
      dev_rvalid = 1'b0;
      #1;
      chk("cont_drained", 64'(rvalid), 64'd0);

      // Full stall with withheld responses.
      req = 2'b01;
      #1;
      chk("full_gnt1", 64'(gnt), 64'b01);
      tick;
      chk("full_gnt2", 64'(gnt), 64'b01);
      tick;
      chk("full_req", 64'(dev_req), 64'd0);
      chk("full_nognt", 64'(gnt), 64'd0);
      tick;
      dev_rvalid = 1'b1;
      #1;
      chk("full_pop_rvalid", 64'(rvalid), 64'b01);
      chk("full_pop_req", 64'(dev_req), 64'd0);
      tick;
      dev_rvalid = 1'b0;
      #1;
      chk("full_resume_req", 64'(dev_req), 64'd1);
      chk("full_resume_gnt", 64'(gnt), 64'b01);
      tick;
      req = 2'b00; dev_rvalid = 1'b1;
      #1;
      chk("full_drain1", 64'(rvalid), 64'b01);
      tick;
      chk("full_drain2", 64'(rvalid), 64'b01);
      tick;
      dev_rvalid = 1'b0;

      // Back-pressure: pointer sits at host1.
      req = 2'b10; dev_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_gnt", 64'(gnt), 64'd0);
         chk("bp_req", 64'(dev_req), 64'd1);
         chk("bp_addr", 64'(dev_addr), 64'(A1));
         chk("bp_wdata", 64'(dev_wdata), 64'h1111_2222);
         tick;
      end
      req = 2'b11; dev_gnt = 1'b1;
      #1;
      chk("bp_release_gnt", 64'(gnt), 64'b10);
      tick;
      req = 2'b00; dev_gnt = 1'b0;

      // Error response, then a spurious one.
      dev_rvalid = 1'b1; dev_err = 1'b1;
      #1;
      chk("err_rvalid", 64'(rvalid), 64'b10);
      chk("err_flag", 64'(err), 64'b10);
      chk("err_perr_clear", 64'(perr), 64'd0);
      tick;
      dev_err = 1'b0;
      #1;
      chk("spur_rvalid", 64'(rvalid), 64'd0);
      tick;
      dev_rvalid = 1'b0;
      chk("spur_perr", 64'(perr), 64'd1);
      tick;
      tick;
      chk("spur_sticky", 64'(perr), 64'd1);

      // Reset with one transaction in flight.
      req = 2'b01; dev_gnt = 1'b1;
      #1;
      chk("mid_gnt", 64'(gnt), 64'b01);
      tick;
      req = 2'b00; rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_perr", 64'(perr), 64'd0);
`ifdef BUS_RR_ARBITER_STATS_EN
      chk("mid_gcnt", gcnt, 64'd0);
`endif
      req = 2'b11;
      #1;
      chk("mid_ptr0_gnt", 64'(gnt), 64'b01);
      tick;
      req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1;
      #1;
      chk("mid_rvalid", 64'(rvalid), 64'b01);
      tick;
      chk("mid_empty_rvalid", 64'(rvalid), 64'd0);
      tick;
      dev_rvalid = 1'b0;
      chk("mid_perr_set", 64'(perr), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
